// File: rtl/ws2812_frame_seq.sv
// Purpose: Z80-side pixel buffer and frame sequencer that streams GRB words to a WS2812 serializer.
// Latency: GO -> first pix_valid_o after 2 clocks; one bubble clock between pixels; latch gap of RESET_CYCLES clocks after the serializer drains.
// Backpressure: pix_data_o/pix_valid_o are held until pix_ready_i; the latch gap only starts once tx_busy_i is low.
//
// Ports:
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   cs_i, wr_n, reg_addr_i,  CPU register window: one write per clock when cs_i=1 and wr_n=0
//   data_i, data_o           write data; read data (combinational from reg_addr_i)
//   pix_data_o, pix_valid_o, pixel stream {G,R,B} with valid/ready handshake
//   pix_ready_i
//   tx_busy_i                serializer still shifting the last word
//   busy_o, frame_done_o     frame in progress; one-clock pulse at the end of the latch gap
//
// Register map: 0 CTRL (W: bit0 GO, bit1 AUTO; R: {BUSY,5'b0,AUTO,1'b0}),
//   1 COUNT (pixels-1, saturating), 2 INDEX (write pointer, wraps to 0),
//   3 R, 4 G, 5 B (writing B commits {G,R,B} at INDEX and bumps INDEX), 6/7 read 0.
module ws2812_frame_seq #(
  parameter int NUM_PIXELS   = 16,
  parameter int IDX_W        = 8,
  parameter int RESET_CYCLES = 2014
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cs_i,
  input  logic        wr_n,
  input  logic [2:0]  reg_addr_i,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic [23:0] pix_data_o,
  output logic        pix_valid_o,
  input  logic        pix_ready_i,
  input  logic        tx_busy_i,
  output logic        busy_o,
  output logic        frame_done_o
);

  localparam int AW    = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RESET_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_PRESENT = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_LATCH   = 3'd4;

  logic [2:0]       r_state;
  logic             r_auto;
  logic [IDX_W-1:0] r_count;
  logic [IDX_W-1:0] r_index;
  logic [7:0]       r_red;
  logic [7:0]       r_grn;
  logic [7:0]       r_blu;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [23:0]      r_pix;

  // Sized to the address width so every index value selects a real entry.
  logic [23:0]      r_buf [0:(1<<AW)-1];

  logic             w_wr;
  logic             w_go;
  logic             w_commit;
  logic             w_last;
  logic             w_latch_end;
  logic [IDX_W-1:0] w_count_wr;
  logic [IDX_W-1:0] w_index_wr;
  logic [IDX_W-1:0] w_index_inc;

  assign w_wr        = cs_i && !wr_n;
  assign w_go        = w_wr && (reg_addr_i == 3'd0) && data_i[0];
  assign w_commit    = w_wr && (reg_addr_i == 3'd5);

  // COUNT is re-sampled at every pointer compare. If it is lowered below a
  // pixel already sent, the frame ends at the next transfer rather than
  // running the pointer past the buffer.
  assign w_last      = (r_ptr >= r_count);
  assign w_latch_end = (r_state == S_LATCH) && (r_cnt == LAST_CNT);

  assign w_count_wr  = (int'(data_i) >= NUM_PIXELS) ? LAST_IDX : IDX_W'(data_i);
  assign w_index_wr  = (int'(data_i) >= NUM_PIXELS) ? '0 : IDX_W'(data_i);
  assign w_index_inc = (r_index == LAST_IDX) ? '0 : r_index + IDX_W'(1);

  // Pixel storage carries no reset; contents are meaningless until written.
  always_ff @(posedge clk_i) begin
    if (w_commit) begin
      r_buf[r_index[AW-1:0]] <= {r_grn, r_red, data_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_auto  <= 1'b0;
      r_count <= '0;
      r_index <= '0;
      r_red   <= '0;
      r_grn   <= '0;
      r_blu   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_pix   <= '0;
    end else begin
      // CPU register writes are accepted in every state.
      if (w_wr) begin
        case (reg_addr_i)
          3'd0: r_auto  <= data_i[1];
          3'd1: r_count <= w_count_wr;
          3'd2: r_index <= w_index_wr;
          3'd3: r_red   <= data_i;
          3'd4: r_grn   <= data_i;
          3'd5: begin
            r_blu   <= data_i;
            r_index <= w_index_inc;
          end
          default: ;
        endcase
      end

      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_ptr   <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // A commit to the same entry in this clock lands after the read,
          // so the word presented is the previous contents.
          r_pix   <= r_buf[r_ptr[AW-1:0]];
          r_state <= S_PRESENT;
        end
        S_PRESENT: begin
          if (pix_ready_i) begin
            if (w_last) begin
              r_state <= S_DRAIN;
            end else begin
              r_ptr   <= r_ptr + IDX_W'(1);
              r_state <= S_LOAD;
            end
          end
        end
        S_DRAIN: begin
          if (!tx_busy_i) begin
            r_cnt   <= '0;
            r_state <= S_LATCH;
          end
        end
        S_LATCH: begin
          if (r_cnt == LAST_CNT) begin
            if (r_auto) begin
              r_ptr   <= '0;
              r_state <= S_LOAD;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Decoded straight from the state register so reset drops them at once.
  assign pix_valid_o  = (r_state == S_PRESENT);
  assign busy_o       = (r_state != S_IDLE);
  assign frame_done_o = w_latch_end;
  assign pix_data_o   = r_pix;

  always_comb begin
    data_o = 8'h00;
    case (reg_addr_i)
      3'd0:    data_o = {busy_o, 5'b00000, r_auto, 1'b0};
      3'd1:    data_o = 8'(r_count);
      3'd2:    data_o = 8'(r_index);
      3'd3:    data_o = r_red;
      3'd4:    data_o = r_grn;
      3'd5:    data_o = r_blu;
      default: data_o = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_ws2812_frame_seq.sv
// Purpose: self-checking bench for ws2812_frame_seq against a register/frame model.
// Latency: expects the latch pulse max(tx_busy hold,1)+RESET_CYCLES clocks after the last transfer.
// Backpressure: drives random pix_ready_i and tx_busy_i holds; checks hold-while-stalled.
module tb_ws2812_frame_seq;
  localparam int NP = 16;
  localparam int RC = 2014;
  localparam int BUDGET = 4000;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        cs_i = 1'b0;
  logic        wr_n = 1'b1;
  logic [2:0]  reg_addr_i = 3'd0;
  logic [7:0]  data_i = 8'h00;
  logic [7:0]  data_o;
  logic [23:0] pix_data_o;
  logic        pix_valid_o;
  logic        pix_ready_i = 1'b0;
  logic        tx_busy_i = 1'b0;
  logic        busy_o;
  logic        frame_done_o;

  ws2812_frame_seq #(.NUM_PIXELS(NP), .IDX_W(8), .RESET_CYCLES(RC)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .cs_i(cs_i), .wr_n(wr_n),
    .reg_addr_i(reg_addr_i), .data_i(data_i), .data_o(data_o),
    .pix_data_o(pix_data_o), .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i),
    .tx_busy_i(tx_busy_i), .busy_o(busy_o), .frame_done_o(frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  // Register-level model of the CPU view.
  logic [23:0] m_buf [NP];
  int          m_index = 0;
  int          m_count = 0;
  logic        m_auto = 1'b0;
  logic [7:0]  m_r = 0, m_g = 0, m_b = 0;

  logic [23:0] got_q[$];
  int          gap;
  bit          done_seen;

  function automatic void model_write(input int a, input logic [7:0] d);
    case (a)
      0: m_auto = d[1];
      1: m_count = (int'(d) >= NP) ? NP - 1 : int'(d);
      2: m_index = (int'(d) >= NP) ? 0 : int'(d);
      3: m_r = d;
      4: m_g = d;
      5: begin
        m_b = d;
        m_buf[m_index] = {m_g, m_r, d};
        m_index = (m_index + 1) % NP;
      end
      default: ;
    endcase
  endfunction

  function automatic void model_reset();
    m_index = 0; m_count = 0; m_auto = 1'b0; m_r = 0; m_g = 0; m_b = 0;
  endfunction

  task automatic wr(input int a, input logic [7:0] d);
    @(negedge clk_i);
    cs_i = 1'b1; wr_n = 1'b0; reg_addr_i = a[2:0]; data_i = d;
    model_write(a, d);
    @(negedge clk_i);
    cs_i = 1'b0; wr_n = 1'b1;
  endtask

  task automatic rd(input int a, output logic [7:0] v);
    @(negedge clk_i);
    reg_addr_i = a[2:0];
    #1 v = data_o;
  endtask

  task automatic put_pix(input int idx, input logic [23:0] w);
    wr(2, 8'(idx));
    wr(3, w[15:8]);
    wr(4, w[23:16]);
    wr(5, w[7:0]);
  endtask

  // Runs one frame to its frame_done_o pulse. Ready is held low for 'hold'
  // cycles then asserted with probability pct%. Each transfer raises tx_busy_i
  // for busy_len cycles. An optional single CPU write is issued at cycle wr_at.
  task automatic collect(input int hold, input int pct, input int busy_len,
                         input int wr_at, input int wa, input logic [7:0] wd);
    int cyc = 0;
    int last_t = -1;
    bit prev_xfer = 0;
    bit prev_stall = 0;
    logic [23:0] prev_dat = '0;
    got_q.delete();
    done_seen = 0;
    gap = -1;
    while (!done_seen && cyc < BUDGET) begin
      @(negedge clk_i);
      cs_i = 1'b0; wr_n = 1'b1;
      if (cyc == wr_at) begin
        cs_i = 1'b1; wr_n = 1'b0; reg_addr_i = wa[2:0]; data_i = wd;
        model_write(wa, wd);
      end
      if (last_t >= 0 && cyc - last_t == busy_len) tx_busy_i = 1'b0;
      if (frame_done_o === 1'b1) begin
        done_seen = 1;
        gap = cyc - last_t;
      end
      if (prev_xfer) begin
        total++;
        if (pix_valid_o !== 1'b0) begin
          bad++;
          $display("FAIL bubble: pix_valid_o=%b after transfer, required 0", pix_valid_o);
        end
      end
      if (prev_stall) begin
        total++;
        if (pix_valid_o !== 1'b1 || pix_data_o !== prev_dat) begin
          bad++;
          $display("FAIL stall_hold: valid=%b data=%06h, required valid=1 data=%06h",
                   pix_valid_o, pix_data_o, prev_dat);
        end
      end
      prev_xfer = 0;
      prev_stall = 0;
      pix_ready_i = (cyc >= hold) && ($urandom_range(99) < pct);
      if (pix_valid_o === 1'b1) begin
        if (pix_ready_i) begin
          got_q.push_back(pix_data_o);
          last_t = cyc;
          prev_xfer = 1;
          if (busy_len > 0) tx_busy_i = 1'b1;
        end else begin
          prev_stall = 1;
          prev_dat = pix_data_o;
        end
      end
      cyc++;
    end
    cs_i = 1'b0; wr_n = 1'b1; pix_ready_i = 1'b0; tx_busy_i = 1'b0;
    total++;
    if (!done_seen) begin
      bad++;
      $display("FAIL frame_timeout: no frame_done_o within %0d cycles", BUDGET);
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (pix_valid_o !== 1'b0 || busy_o !== 1'b0 || frame_done_o !== 1'b0 || pix_data_o !== 24'h0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b busy=%b done=%b data=%06h, required all 0",
               pix_valid_o, busy_o, frame_done_o, pix_data_o);
    end
    for (int a = 0; a < 8; a++) begin
      reg_addr_i = a[2:0];
      #1;
      total++;
      if (data_o !== 8'h00) begin
        bad++;
        $display("FAIL reset_reg%0d: got %02h, required 00", a, data_o);
      end
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_single_pixel();
    logic [7:0] v;
    wr(2, 8'h00); wr(3, 8'h11); wr(4, 8'h22); wr(5, 8'h33);
    rd(2, v);
    total++;
    if (v !== 8'(m_index)) begin
      bad++;
      $display("FAIL single_index: INDEX=%02h, required %02h", v, 8'(m_index));
    end
    wr(1, 8'h00);
    wr(0, 8'h01);
    collect(0, 100, 0, -1, 0, 8'h00);
    total++;
    if (got_q.size() != 1 || got_q[0] !== 24'h221133) begin
      bad++;
      $display("FAIL single_word: count=%0d first=%06h, required 1 x 221133",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 24'h0);
    end
    total++;
    if (gap != RC + 1) begin
      bad++;
      $display("FAIL single_gap: %0d cycles to frame_done_o, required %0d", gap, RC + 1);
    end
  endtask

  task automatic test_stall_order();
    for (int i = 0; i < 4; i++) put_pix(i, 24'($urandom));
    wr(1, 8'd3);
    wr(0, 8'h01);
    collect(10, 100, 0, -1, 0, 8'h00);
    total++;
    if (got_q.size() != 4) begin
      bad++;
      $display("FAIL stall_count: %0d transfers, required 4", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      total++;
      if (got_q[i] !== m_buf[i]) begin
        bad++;
        $display("FAIL stall_word%0d: got %06h, required %06h", i, got_q[i], m_buf[i]);
      end
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++) begin
      int n;
      n = $urandom_range(NP - 1);
      for (int i = 0; i <= n; i++) put_pix(i, 24'($urandom));
      wr(1, 8'(n));
      wr(0, 8'h01);
      collect($urandom_range(3), $urandom_range(30, 100), 0, -1, 0, 8'h00);
      total++;
      if (got_q.size() != m_count + 1) begin
        bad++;
        $display("FAIL rand%0d_count: %0d transfers, required %0d", f, got_q.size(), m_count + 1);
      end
      for (int i = 0; i < got_q.size() && i <= m_count; i++) begin
        total++;
        if (got_q[i] !== m_buf[i]) begin
          bad++;
          $display("FAIL rand%0d_word%0d: got %06h, required %06h", f, i, got_q[i], m_buf[i]);
        end
      end
    end
  endtask

  task automatic test_auto();
    logic [7:0] v;
    for (int i = 0; i < 3; i++) put_pix(i, 24'($urandom));
    wr(1, 8'd2);
    wr(0, 8'h03);
    for (int f = 0; f < 2; f++) begin
      // The second frame clears AUTO while it is running.
      collect(0, 70, 0, (f == 1) ? 1 : -1, 0, 8'h00);
      total++;
      if (got_q.size() != 3) begin
        bad++;
        $display("FAIL auto%0d_count: %0d transfers, required 3", f, got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < 3; i++) begin
        total++;
        if (got_q[i] !== m_buf[i]) begin
          bad++;
          $display("FAIL auto%0d_word%0d: got %06h, required %06h", f, i, got_q[i], m_buf[i]);
        end
      end
      @(negedge clk_i);
      total++;
      if (busy_o !== (f == 0)) begin
        bad++;
        $display("FAIL auto%0d_busy_after: busy_o=%b, required %b", f, busy_o, (f == 0));
      end
    end
    begin
      int extra = 0;
      repeat (40) begin
        @(negedge clk_i);
        if (frame_done_o !== 1'b0 || pix_valid_o !== 1'b0) extra++;
      end
      total++;
      if (extra != 0) begin
        bad++;
        $display("FAIL auto_stopped: %0d active cycles after AUTO cleared, required 0", extra);
      end
    end
    rd(0, v);
    total++;
    if (v !== 8'h00) begin
      bad++;
      $display("FAIL auto_ctrl: CTRL=%02h, required 00", v);
    end
  endtask

  task automatic test_bounds();
    logic [7:0] v;
    wr(2, 8'(NP + 3));
    rd(2, v);
    total++;
    if (v !== 8'(m_index)) begin bad++; $display("FAIL index_wrap: got %02h, required %02h", v, 8'(m_index)); end
    wr(1, 8'hFF);
    rd(1, v);
    total++;
    if (v !== 8'(m_count)) begin bad++; $display("FAIL count_sat: got %02h, required %02h", v, 8'(m_count)); end
    wr(1, 8'(NP));
    rd(1, v);
    total++;
    if (v !== 8'(NP - 1)) begin bad++; $display("FAIL count_sat_np: got %02h, required %02h", v, 8'(NP - 1)); end
    put_pix(NP - 1, 24'($urandom));
    rd(2, v);
    total++;
    if (v !== 8'(m_index)) begin bad++; $display("FAIL index_commit_wrap: got %02h, required %02h", v, 8'(m_index)); end
    rd(3, v);
    total++;
    if (v !== m_r) begin bad++; $display("FAIL stage_r: got %02h, required %02h", v, m_r); end
    rd(5, v);
    total++;
    if (v !== m_b) begin bad++; $display("FAIL stage_b: got %02h, required %02h", v, m_b); end
    wr(6, 8'h5A); wr(7, 8'hA5);
    for (int a = 6; a < 8; a++) begin
      rd(a, v);
      total++;
      if (v !== 8'h00) begin bad++; $display("FAIL reg%0d_zero: got %02h, required 00", a, v); end
    end
  endtask

  task automatic test_txbusy_go();
    int n;
    n = $urandom_range(2, 5);
    for (int i = 0; i <= n; i++) put_pix(i, 24'($urandom));
    wr(1, 8'(n));
    wr(0, 8'h01);
    // A second GO mid-frame must not restart or extend the frame.
    collect(0, 100, 500, 2, 0, 8'h01);
    total++;
    if (got_q.size() != n + 1) begin
      bad++;
      $display("FAIL txbusy_count: %0d transfers, required %0d", got_q.size(), n + 1);
    end
    total++;
    if (gap != 500 + RC) begin
      bad++;
      $display("FAIL txbusy_gap: %0d cycles to frame_done_o, required %0d", gap, 500 + RC);
    end
    repeat (3) @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL go_ignored: busy_o=%b after frame, required 0", busy_o);
    end
  endtask

  task automatic test_midframe_write();
    logic [23:0] nw;
    for (int i = 0; i < 6; i++) put_pix(i, 24'($urandom));
    nw = 24'($urandom);
    wr(2, 8'd5);
    wr(3, nw[15:8]);
    wr(4, nw[23:16]);
    wr(1, 8'd5);
    wr(0, 8'h01);
    collect(0, 100, 0, 0, 5, nw[7:0]);
    total++;
    if (got_q.size() != 6 || got_q[5] !== nw) begin
      bad++;
      $display("FAIL midframe_write: count=%0d last=%06h, required 6 ending %06h",
               got_q.size(), (got_q.size() > 5) ? got_q[5] : 24'h0, nw);
    end
    for (int i = 0; i < got_q.size() && i < 5; i++) begin
      total++;
      if (got_q[i] !== m_buf[i]) begin
        bad++;
        $display("FAIL midframe_word%0d: got %06h, required %06h", i, got_q[i], m_buf[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] v;
    int w = 0;
    for (int i = 0; i < 4; i++) put_pix(i, 24'($urandom));
    wr(1, 8'd3);
    wr(0, 8'h03);
    while (pix_valid_o !== 1'b1 && w < 10) begin
      @(negedge clk_i);
      w++;
    end
    total++;
    if (pix_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL rst_setup: pix_valid_o=%b before reset, required 1", pix_valid_o);
    end
    #2 rst_n_i = 1'b0;
    model_reset();
    #1;
    total++;
    if (pix_valid_o !== 1'b0 || busy_o !== 1'b0 || pix_data_o !== 24'h0 || frame_done_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: valid=%b busy=%b data=%06h done=%b, required all 0",
               pix_valid_o, busy_o, pix_data_o, frame_done_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int a = 0; a < 6; a++) begin
      rd(a, v);
      total++;
      if (v !== 8'h00) begin bad++; $display("FAIL rst_reg%0d: got %02h, required 00", a, v); end
    end
    put_pix(0, 24'($urandom));
    put_pix(1, 24'($urandom));
    wr(1, 8'd1);
    wr(0, 8'h01);
    collect(0, 100, 0, -1, 0, 8'h00);
    total++;
    if (got_q.size() != 2) begin
      bad++;
      $display("FAIL rst_restart_count: %0d transfers, required 2", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      total++;
      if (got_q[i] !== m_buf[i]) begin
        bad++;
        $display("FAIL rst_restart_word%0d: got %06h, required %06h", i, got_q[i], m_buf[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_stall_order();
    test_random_frames();
    test_auto();
    test_bounds();
    test_txbusy_go();
    test_midframe_write();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
